prefetch_request_handler: RTL

PREFETCH_REQUEST_HANDLER -- requirements
Module: prefetch_request_handler

---
 rtl/prefetch_pkg.sv | 6 +
 rtl/prefetch_fifo.sv | 40 ++++
 rtl/prefetch_request_handler.sv | 78 +++++++
 3 files changed

// File: rtl/prefetch_pkg.sv
// prefetch_pkg: FSM state type and default sizing shared by the prefetch request handler slice
package prefetch_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FILL} state_e;
  localparam int DEF_QUEUE_DEPTH = 4;
  localparam int DEF_LINE_SIZE = 256;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: pending-request FIFO exposing every slot so the handler can compare against queued lines
module prefetch_fifo import prefetch_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [WIDTH-1:0]              data_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [WIDTH-1:0]              head_o,
  output logic [DEPTH-1:0][WIDTH-1:0]   ent_addr_o,
  output logic [DEPTH-1:0]              ent_valid_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o = mem_q[rd_q];
  assign ent_addr_o = mem_q;
  // a slot is live when its distance from the read pointer is below the occupancy
  always_comb
    for (int i = 0; i < DEPTH; i++) ent_valid_o[i] = {1'b0, AW'(i) - rd_q} < cnt_q;
endmodule

// File: rtl/prefetch_request_handler.sv
// prefetch_request_handler: queues line-aligned prefetches and issues them one at a time to memory.
// Define PF_DEDUP_EN to drop requests already queued or in flight.
module prefetch_request_handler import prefetch_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int LINE_SIZE = DEF_LINE_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lo_prefetch_valid_i,
  input  logic [WIDTH-1:0] lo_prefetch_address_i,
  output logic             lo_ready_o,
  output logic             mem_req_o,
  output logic [WIDTH-1:0] mem_addr_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  output logic             fill_valid_o,
  output logic [WIDTH-1:0] fill_address_o,
  output logic             fill_prefetched_o,
  input  logic             fill_ready_i,
  output logic             busy_o,
  output logic [15:0]      drop_count_o
);
`ifdef PF_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  state_e state_q, state_d;
  logic rdy_q, full, empty, accept, push, pop, match;
  logic [WIDTH-1:0] addr_al, head, inflight_q, inflight_d;
  logic [QUEUE_DEPTH-1:0][WIDTH-1:0] ent_addr;
  logic [QUEUE_DEPTH-1:0] ent_valid;
  logic [15:0] drop_q, drop_d;
  prefetch_fifo #(.WIDTH(WIDTH), .DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .data_i(addr_al),
    .full_o(full), .empty_o(empty), .head_o(head),
    .ent_addr_o(ent_addr), .ent_valid_o(ent_valid)
  );
  assign addr_al = lo_prefetch_address_i & ~WIDTH'(LINE_SIZE - 1);
  // rdy_q keeps ready low while in reset and for the release edge itself
  assign lo_ready_o = rdy_q & ~full;
  assign accept = lo_prefetch_valid_i & lo_ready_o;
  always_comb begin
    match = (state_q != IDLE) && (inflight_q == addr_al);
    for (int i = 0; i < QUEUE_DEPTH; i++) match = match | (ent_valid[i] && ent_addr[i] == addr_al);
  end
  assign push = accept & ~(DEDUP & match);
  assign pop = (state_q == IDLE) & ~empty;
  assign inflight_d = pop ? head : inflight_q;
  assign drop_d = drop_q + 16'(accept & DEDUP & match);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      inflight_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q <= 1'b1;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
    end
  always_comb
    state_d = state_q == IDLE  ? (empty ? IDLE : ISSUE) :
              state_q == ISSUE ? (mem_gnt_i ? WAIT : ISSUE) :
              state_q == WAIT  ? (mem_rvalid_i ? FILL : WAIT) :
                                 (fill_ready_i ? IDLE : FILL);
  always_comb begin
    mem_req_o = state_q == ISSUE;
    mem_addr_o = state_q == ISSUE ? inflight_q : '0;
    fill_valid_o = state_q == FILL;
    fill_address_o = state_q == FILL ? inflight_q : '0;
    fill_prefetched_o = state_q == FILL;
    busy_o = ~empty | (state_q != IDLE);
    drop_count_o = drop_q;
  end
endmodule
